// File: rtl/cam_pkg.sv
// Shared helpers for the associative store.
package cam_pkg;

  // Bit positions of the write-line pair for one word bit.
  localparam int unsigned WL_SET = 0;
  localparam int unsigned WL_CLR = 1;

  // Resolve one write-line pair against the current bit value.
  function automatic logic write_bit(input logic cur, input logic set_line, input logic clr_line);
    logic res;
    res = cur;
    case ({set_line, clr_line})
      2'b10:   res = 1'b1;
      2'b01:   res = 1'b0;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cam_cell.sv
// One associative cell: a word, its tag, masked match and tagged write.
module cam_cell
  import cam_pkg::*;
#(
  parameter int unsigned num_bits = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set,
  input  logic                  search,
  input  logic                  first_keep,
  input  logic [num_bits-1:0]   comparand,
  input  logic [num_bits-1:0]   mask,
  input  logic [2*num_bits-1:0] write_lines,
  output logic                  tag,
  output logic [num_bits-1:0]   gated_word
);

  logic [num_bits-1:0] word;
  logic [num_bits-1:0] word_next;
  logic                match;

  assign match      = ((word ^ comparand) & mask) == '0;
  assign gated_word = {num_bits{tag}} & word;

  // Next word: apply write-line pairs only while this cell is tagged.
  always_comb begin
    word_next = word;
    if (tag) begin
      for (int unsigned i = 0; i < num_bits; i++) begin
        word_next[i] = write_bit(word[i], write_lines[2*i+WL_SET], write_lines[2*i+WL_CLR]);
      end
    end
  end

  // Word and tag registers; first_keep carries both the hold and the
  // select-first decision, so it is the fallback when set/search are idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      tag  <= 1'b0;
    end else begin
      word <= word_next;
      if (set)         tag <= 1'b1;
      else if (search) tag <= tag & match;
      else             tag <= first_keep;
    end
  end

endmodule

// File: rtl/cam.sv
// Content-addressable parallel processor array with global tag commands.
module cam
  import cam_pkg::*;
#(
  parameter int unsigned num_bits  = 32,
  parameter int unsigned num_cells = 100
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [num_bits-1:0]   comparand,
  input  logic [num_bits-1:0]   mask,
  input  logic                  perform_search,
  input  logic                  set,
  input  logic                  select_first,
  input  logic [2*num_bits-1:0] write_lines,
  output logic [num_cells-1:0]  tag_wires,
  output logic [num_bits-1:0]   read_lines
);

  logic [num_cells-1:0] first_keep;
  logic [num_bits-1:0]  gated_words [num_cells];

  // Priority chain: with select_first, a tag survives only if no lower
  // cell is tagged; otherwise every tag simply holds.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    first_keep = '0;
    for (int unsigned c = 0; c < num_cells; c++) begin
      first_keep[c] = tag_wires[c] & ~(select_first & seen);
      seen          = seen | tag_wires[c];
    end
  end

  // Wired-OR read of all tagged words (untagged cells contribute zero).
  always_comb begin
    read_lines = '0;
    for (int unsigned c = 0; c < num_cells; c++) begin
      read_lines = read_lines | gated_words[c];
    end
  end

  for (genvar c = 0; c < num_cells; c++) begin : g_cell
    cam_cell #(
      .num_bits(num_bits)
    ) u_cell (
      .clk        (CLK),
      .rst_n      (RST_N),
      .set        (set),
      .search     (perform_search),
      .first_keep (first_keep[c]),
      .comparand  (comparand),
      .mask       (mask),
      .write_lines(write_lines),
      .tag        (tag_wires[c]),
      .gated_word (gated_words[c])
    );
  end

endmodule

// File: tb/tb_cam.sv
// Self-checking bench for cam against a word/tag array reference model.
module tb_cam;

  localparam int NB = 32;
  localparam int NC = 100;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic [NB-1:0]   comparand = '0;
  logic [NB-1:0]   mask = '0;
  logic            perform_search = 1'b0;
  logic            set = 1'b0;
  logic            select_first = 1'b0;
  logic [2*NB-1:0] write_lines = '0;
  logic [NC-1:0]   tag_wires;
  logic [NB-1:0]   read_lines;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] m_word [NC];
  bit            m_tag  [NC];

  cam #(.num_bits(NB), .num_cells(NC)) dut (
    .CLK(CLK), .RST_N(RST_N), .comparand(comparand), .mask(mask),
    .perform_search(perform_search), .set(set), .select_first(select_first),
    .write_lines(write_lines), .tag_wires(tag_wires), .read_lines(read_lines)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*NB-1:0] wl_of(input logic [NB-1:0] val, input logic [NB-1:0] msk);
    logic [2*NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      if (msk[i]) begin
        if (val[i]) r[2*i] = 1'b1;
        else        r[2*i+1] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic [NC-1:0] model_tags();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = m_tag[c];
    return r;
  endfunction

  function automatic logic [NB-1:0] model_read();
    logic [NB-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) if (m_tag[c]) r = r | m_word[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_word[c] = '0;
      m_tag[c]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit s, input bit srch, input bit sel,
                            input logic [NB-1:0] cmp, input logic [NB-1:0] msk,
                            input logic [2*NB-1:0] wl);
    bit            nt [NC];
    logic [NB-1:0] ones, zeros;
    int            first;
    first = -1;
    for (int c = 0; c < NC; c++) if (m_tag[c] && first < 0) first = c;
    for (int c = 0; c < NC; c++) begin
      if (s)         nt[c] = 1'b1;
      else if (srch) nt[c] = m_tag[c] && (((m_word[c] ^ cmp) & msk) == 0);
      else if (sel)  nt[c] = (c == first);
      else           nt[c] = m_tag[c];
    end
    ones = '0; zeros = '0;
    for (int i = 0; i < NB; i++) begin
      ones[i]  = wl[2*i] & ~wl[2*i+1];
      zeros[i] = wl[2*i+1] & ~wl[2*i];
    end
    for (int c = 0; c < NC; c++) begin
      if (m_tag[c]) m_word[c] = (m_word[c] | ones) & ~zeros;
      m_tag[c] = nt[c];
    end
  endtask

  // Drive one cycle of commands, update model at the edge, sample 1 after.
  task automatic cycle(input bit s, input bit srch, input bit sel,
                       input logic [NB-1:0] cmp, input logic [NB-1:0] msk,
                       input logic [2*NB-1:0] wl);
    set = s; perform_search = srch; select_first = sel;
    comparand = cmp; mask = msk; write_lines = wl;
    @(posedge CLK);
    model_step(s, srch, sel, cmp, msk, wl);
    #1;
    set = 1'b0; perform_search = 1'b0; select_first = 1'b0; write_lines = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    checks++; if (tag_wires !== '0) begin errors++; $display("FAIL reset_tags got %h exp 0", tag_wires); end
    checks++; if (read_lines !== '0) begin errors++; $display("FAIL reset_read got %h exp 0", read_lines); end
    @(negedge CLK) RST_N = 1'b1;
    cycle(0, 0, 0, '0, '0, '1);
    checks++; if (tag_wires !== '0) begin errors++; $display("FAIL untagged_write_tags got %h exp 0", tag_wires); end
    checks++; if (read_lines !== 32'h0) begin errors++; $display("FAIL untagged_write_read got %h exp 0", read_lines); end
  endtask

  task automatic test_set_write();
    logic [NC-1:0] all1;
    all1 = '1;
    cycle(1, 0, 0, '0, '0, '0);
    checks++; if (tag_wires !== all1) begin errors++; $display("FAIL set_all got %h exp %h", tag_wires, all1); end
    cycle(0, 0, 0, '0, '0, wl_of(32'd56, 32'h3FF));
    checks++; if (read_lines !== 32'h38) begin errors++; $display("FAIL write56_read got %h exp 38", read_lines); end
    checks++; if (read_lines !== model_read()) begin errors++; $display("FAIL write56_model got %h exp %h", read_lines, model_read()); end
  endtask

  task automatic test_search();
    logic [NC-1:0] all1;
    all1 = '1;
    cycle(1, 0, 0, '0, '0, '0);
    cycle(0, 1, 0, 32'd56, '1, '0);
    checks++; if (tag_wires !== all1) begin errors++; $display("FAIL search56 got %h exp %h", tag_wires, all1); end
    cycle(0, 1, 0, 32'd57, '1, '0);
    checks++; if (tag_wires !== '0) begin errors++; $display("FAIL search57_tags got %h exp 0", tag_wires); end
    checks++; if (read_lines !== '0) begin errors++; $display("FAIL search57_read got %h exp 0", read_lines); end
  endtask

  task automatic test_select_first();
    logic [NC-1:0] one;
    one = '0; one[0] = 1'b1;
    cycle(1, 0, 0, '0, '0, '0);
    cycle(0, 0, 1, '0, '0, '0);
    checks++; if (tag_wires !== one) begin errors++; $display("FAIL select_first got %h exp %h", tag_wires, one); end
    cycle(0, 0, 0, '0, '0, wl_of(32'hFF, 32'hFF));
    checks++; if (read_lines !== 32'hFF) begin errors++; $display("FAIL cell0_write got %h exp ff", read_lines); end
    cycle(0, 1, 0, 32'h1, '1, '0);
    cycle(0, 0, 1, '0, '0, '0);
    checks++; if (tag_wires !== '0) begin errors++; $display("FAIL select_none got %h exp 0", tag_wires); end
  endtask

  task automatic test_masked_search();
    logic [NC-1:0] one, all1;
    one = '0; one[0] = 1'b1; all1 = '1;
    cycle(1, 0, 0, '0, '0, '0);
    cycle(0, 1, 0, 32'hFF, 32'hFF, '0);
    checks++; if (tag_wires !== one) begin errors++; $display("FAIL search_ff got %h exp %h", tag_wires, one); end
    cycle(1, 0, 0, '0, '0, '0);
    cycle(0, 1, 0, 32'h38, 32'h38, '0);
    checks++; if (tag_wires !== all1) begin errors++; $display("FAIL search_38 got %h exp %h", tag_wires, all1); end
    cycle(0, 1, 0, 32'hDEAD_BEEF, '0, '0);
    checks++; if (tag_wires !== all1) begin errors++; $display("FAIL search_mask0 got %h exp %h", tag_wires, all1); end
  endtask

  task automatic test_priority();
    logic [NC-1:0] all1;
    all1 = '1;
    cycle(0, 1, 0, 32'h1234_5678, '1, '0);
    cycle(1, 1, 1, 32'h1234_5678, '1, '0);
    checks++; if (tag_wires !== all1) begin errors++; $display("FAIL set_wins got %h exp %h", tag_wires, all1); end
    cycle(0, 0, 0, '0, '0, '1);
    checks++; if (read_lines !== 32'hFF) begin errors++; $display("FAIL both_lines_hold got %h exp ff", read_lines); end
    cycle(0, 1, 1, 32'h38, 32'hFF, '0);
    checks++; if (tag_wires !== model_tags()) begin errors++; $display("FAIL search_over_first got %h exp %h", tag_wires, model_tags()); end
  endtask

  task automatic test_idempotent();
    logic [NB-1:0] v;
    v = $urandom;
    cycle(1, 0, 0, '0, '0, '0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, '0, '0, wl_of(v, '1));
    checks++; if (read_lines !== v) begin errors++; $display("FAIL write_held got %h exp %h", read_lines, v); end
  endtask

  task automatic test_random();
    bit            s, srch, sel;
    logic [NB-1:0] cmp, msk;
    logic [2*NB-1:0] wl;
    int            op;
    for (int n = 0; n < 400; n++) begin
      op   = $urandom_range(0, 11);
      s    = (op == 0);
      srch = (op >= 1 && op <= 4);
      sel  = (op == 5) || (op == 6 && $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) cmp = m_word[$urandom_range(0, NC-1)];
      else                           cmp = $urandom;
      msk = $urandom & $urandom;
      wl  = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '0;
      cycle(s, srch, sel, cmp, msk, wl);
      checks++; if (tag_wires !== model_tags()) begin errors++; $display("FAIL rand_tags n=%0d got %h exp %h", n, tag_wires, model_tags()); end
      checks++; if (read_lines !== model_read()) begin errors++; $display("FAIL rand_read n=%0d got %h exp %h", n, read_lines, model_read()); end
    end
  endtask

  task automatic test_reset_abort();
    cycle(1, 0, 0, '0, '0, '0);
    set = 1'b1; write_lines = '1;
    #2 RST_N = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    checks++; if (tag_wires !== '0) begin errors++; $display("FAIL abort_tags got %h exp 0", tag_wires); end
    checks++; if (read_lines !== '0) begin errors++; $display("FAIL abort_read got %h exp 0", read_lines); end
    set = 1'b0; write_lines = '0;
    @(negedge CLK) RST_N = 1'b1;
    cycle(1, 0, 0, '0, '0, '0);
    checks++; if (read_lines !== '0) begin errors++; $display("FAIL abort_words got %h exp 0", read_lines); end
  endtask

  initial begin
    test_reset();
    test_set_write();
    test_search();
    test_select_first();
    test_masked_search();
    test_priority();
    test_idempotent();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
